// File: rtl/tx_queue_if.sv
// Register-side and frontend-side signals of the UART transmit queue.
// slave is the queue's view; master is the driver/frontend view.
interface tx_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          push_i;
  logic [7:0]    data_i;
  logic          flush_i;
  logic          clr_overflow_i;
  logic          done_i;
  logic          transmit_o;
  logic [7:0]    dr_o;
  logic          busy_o;
  logic          full_o;
  logic          empty_o;
  logic [CW-1:0] count_o;
  logic          overflow_o;

  modport slave (
    input  push_i, data_i, flush_i, clr_overflow_i, done_i,
    output transmit_o, dr_o, busy_o, full_o, empty_o, count_o, overflow_o
  );

  modport master (
    output push_i, data_i, flush_i, clr_overflow_i, done_i,
    input  transmit_o, dr_o, busy_o, full_o, empty_o, count_o, overflow_o
  );
endinterface

// File: rtl/tx_queue.sv
// Circular transmit FIFO feeding the UART frontend one byte per transmit_o/done_i handshake.
// Optional sticky overflow flag enabled by defining TX_QUEUE_OVERFLOW_EN.
module tx_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  tx_queue_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          xmit_q, xmit_d;
  logic [7:0]    dr_q, dr_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];

  logic push_ok;
  logic pop;

  assign push_ok = bus.push_i && !bus.flush_i && (cnt_q < DEPTH_C);
  assign pop     = (state_q == S_IDLE) && (cnt_q != '0) && !bus.flush_i;

  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    cnt_d   = cnt_q;
    xmit_d  = 1'b0;
    dr_d    = dr_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          dr_d    = mem_q[rp_q];
          xmit_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush clears storage only; an in-flight frame still completes via done_i.
    if (bus.flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wp_d = wp_q + AW'(1);
      if (pop)     rp_d = rp_q + AW'(1);
      cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    end
  end

`ifdef TX_QUEUE_OVERFLOW_EN
  logic drop;
  assign drop = bus.push_i && !bus.flush_i && (cnt_q == DEPTH_C);

  always_comb begin
    ovf_d = ovf_q;
    if (bus.clr_overflow_i) ovf_d = 1'b0;
    if (drop)               ovf_d = 1'b1;
  end
`else
  logic unused_clr;
  assign unused_clr = bus.clr_overflow_i;

  always_comb begin
    ovf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      xmit_q  <= 1'b0;
      dr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      xmit_q  <= xmit_d;
      dr_q    <= dr_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wp_q] <= bus.data_i;
  end

  assign bus.transmit_o = xmit_q;
  assign bus.dr_o       = dr_q;
  assign bus.busy_o     = (state_q == S_WAIT);
  assign bus.full_o     = (cnt_q == DEPTH_C);
  assign bus.empty_o    = (cnt_q == '0);
  assign bus.count_o    = cnt_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_tx_queue.sv
// Self-checking bench for tx_queue: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based transaction model.
module tb_tx_queue;
  localparam int DEPTH = 8;
`ifdef TX_QUEUE_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  tx_queue_if #(.DEPTH(DEPTH)) bus();

  tx_queue #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending bytes, frame-in-flight flag, last handed-off byte.
  logic [7:0] mq[$];
  bit         m_busy;
  bit         m_tx;
  logic [7:0] m_dr;
  bit         m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 0;
    m_tx   = 0;
    m_dr   = 8'h00;
    m_ovf  = 0;
  endtask

  task automatic model_edge(input bit p, input logic [7:0] d, input bit f, input bit c, input bit dn);
    int  n;
    bit  take;
    n    = mq.size();
    take = !m_busy && (n > 0) && !f;
    m_tx = 0;
    if (take) begin
      m_dr   = mq[0];
      m_tx   = 1;
      m_busy = 1;
    end else if (m_busy && dn) begin
      m_busy = 0;
    end
    if (f) begin
      mq.delete();
    end else begin
      if (take) void'(mq.pop_front());
      if (p && n < DEPTH) mq.push_back(d);
    end
    if (OVF_EN) begin
      if (p && !f && n == DEPTH) m_ovf = 1;
      else if (c)                m_ovf = 0;
    end
  endtask

  task automatic compare_all();
    check("transmit", 32'(bus.transmit_o), 32'(m_tx));
    check("dr",       32'(bus.dr_o),       32'(m_dr));
    check("busy",     32'(bus.busy_o),     32'(m_busy));
    check("count",    32'(bus.count_o),    32'(mq.size()));
    check("full",     32'(bus.full_o),     32'(mq.size() == DEPTH));
    check("empty",    32'(bus.empty_o),    32'(mq.size() == 0));
    check("overflow", 32'(bus.overflow_o), 32'(m_ovf));
  endtask

  task automatic step(input bit p, input logic [7:0] d, input bit f, input bit c, input bit dn);
    @(negedge clk);
    bus.push_i         = p;
    bus.data_i         = d;
    bus.flush_i        = f;
    bus.clr_overflow_i = c;
    bus.done_i         = dn;
    @(posedge clk);
    model_edge(p, d, f, c, dn);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0);
  endtask

  // Return done_i a few cycles after each frame starts until the model is drained.
  task automatic drain();
    int guard;
    guard = 0;
    while ((m_busy || mq.size() != 0) && guard < 400) begin
      idle(3);
      step(0, 8'h00, 0, 0, 1);
      guard++;
    end
    check("drain_bound", 32'(guard < 400), 32'd1);
  endtask

  initial begin
    bus.push_i = 0; bus.data_i = 0; bus.flush_i = 0;
    bus.clr_overflow_i = 0; bus.done_i = 0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Single byte: pulse two edges after the push, count already decremented.
    step(1, 8'hA5, 0, 0, 0);
    check("a5_count_after_push", 32'(bus.count_o), 32'd1);
    check("a5_no_tx_yet", 32'(bus.transmit_o), 32'd0);
    step(0, 8'h00, 0, 0, 0);
    check("a5_tx", 32'(bus.transmit_o), 32'd1);
    check("a5_dr", 32'(bus.dr_o), 32'hA5);
    check("a5_busy", 32'(bus.busy_o), 32'd1);
    check("a5_count", 32'(bus.count_o), 32'd0);
    idle(1);
    check("a5_single_pulse", 32'(bus.transmit_o), 32'd0);
    idle(5);
    step(0, 8'h00, 0, 0, 1);
    idle(2);

    // Three bytes, done_i 50 cycles after each pulse.
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(1, 8'h03, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      idle(49);
      step(0, 8'h00, 0, 0, 1);
      if (k < 2) begin
        idle(1);
        check("seq_gap_tx", 32'(bus.transmit_o), 32'd1);
        check("seq_gap_dr", 32'(bus.dr_o), 32'(k + 2));
      end
    end
    idle(3);

    // Overflow with head in flight.
    step(1, 8'h10, 0, 0, 0);
    idle(1);
    for (int k = 0; k < 9; k++) step(1, 8'(8'h20 + k), 0, 0, 0);
    check("ovf_full", 32'(bus.full_o), 32'd1);
    check("ovf_count", 32'(bus.count_o), 32'(DEPTH));
    check("ovf_flag", 32'(bus.overflow_o), 32'(OVF_EN));
    step(0, 8'h00, 0, 1, 0);
    check("ovf_cleared", 32'(bus.overflow_o), 32'd0);
    drain();

    // Flush during WAIT alongside a push.
    step(1, 8'h40, 0, 0, 0);
    idle(1);
    for (int k = 0; k < 4; k++) step(1, 8'(8'h41 + k), 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    check("flush_count", 32'(bus.count_o), 32'd0);
    check("flush_empty", 32'(bus.empty_o), 32'd1);
    check("flush_busy", 32'(bus.busy_o), 32'd1);
    idle(3);
    step(0, 8'h00, 0, 0, 1);
    idle(6);

    // Wrap-around across the pointers.
    for (int k = 0; k < 20; k++) begin
      step(1, 8'(8'h80 + k), 0, 0, 0);
      idle(2);
      step(0, 8'h00, 0, 0, 1);
    end
    drain();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bit p, f, c, dn;
      p  = ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 99) < 2);
      c  = ($urandom_range(0, 99) < 5);
      dn = m_busy ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 5);
      step(p, 8'($urandom), f, c, dn);
    end
    drain();

    // Asynchronous reset mid-WAIT with three entries queued.
    for (int k = 0; k < 4; k++) step(1, 8'(8'hC0 + k), 0, 0, 0);
    check("rst_pre_busy", 32'(bus.busy_o), 32'd1);
    check("rst_pre_count", 32'(bus.count_o), 32'd3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    bus.push_i = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
